uart_mmio_fifo: RTL and testbench

//  Memory-mapped UART front end between the Riscv151 data-memory bus and the on-chip uart.

---
 rtl/uart_mmio_fifo.sv | 110 +++++++++++
 tb/tb_uart_mmio_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: TX/RX byte FIFOs behind STATUS, RX_DATA, TX_DATA and OVF_CNT registers.
// Optional feature macro: UART_OVF_COUNT_EN adds a 16-bit saturating RX-overflow counter at offset 3.
module uart_mmio_fifo #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_drop;
  logic        bus_wr, bus_rd, rx_overflow;
  logic [1:0]  offset;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = addr[3:2];
  assign bus_wr   = sel & (|we);
  assign bus_rd   = sel & re;
  assign rx_ready = 1'b1;
  assign unused_bits = ^{wdata[31:8], addr[1:0]};

  // Pointers carry one extra wrap bit to tell full from empty.
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW-1:0] == tx_rd[AW-1:0]) && (tx_wr[AW] != tx_rd[AW]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW-1:0] == rx_rd[AW-1:0]) && (rx_wr[AW] != rx_rd[AW]);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_valid ? tx_mem[tx_rd[AW-1:0]] : 8'h00;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign tx_pop  = tx_valid & tx_ready;
  assign tx_push = bus_wr & (offset == 2'd2) & (!tx_full | tx_pop);
  assign rx_pop  = bus_rd & (offset == 2'd1) & !rx_empty;
  assign rx_push = rx_valid & (!rx_full | rx_pop);
  assign rx_drop = rx_valid & rx_full & !rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
    end
  end

  // A new drop in the same cycle as a STATUS read keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               rx_overflow <= 1'b0;
    else if (rx_drop)                      rx_overflow <= 1'b1;
    else if (bus_rd && (offset == 2'd0))   rx_overflow <= 1'b0;
  end

`ifdef UART_OVF_COUNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  ovf_cnt <= '0;
    else if (bus_wr && (offset == 2'd3))      ovf_cnt <= '0;
    else if (rx_drop && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      2'd0: rd_mux = {29'b0, rx_overflow, !rx_empty, !tx_full};
      2'd1: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd[AW-1:0]]};
`ifdef UART_OVF_COUNT_EN
      2'd3: rd_mux = {16'b0, ovf_cnt};
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= sel ? rd_mux : 32'h0;
  end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register map, both FIFO paths, boundaries and async reset.
module tb_uart_mmio_fifo;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  we;
  logic        re, sel;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic [31:0] rd;

  uart_mmio_fifo dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .sel(sel), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    @(negedge clk);
    addr = BASE | {28'b0, off, 2'b00};
    wdata = d;
    we = 4'hF;
    @(negedge clk);
    we = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    @(negedge clk);
    addr = BASE | {28'b0, off, 2'b00};
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = BASE; wdata = '0; we = '0; re = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #12;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got=%b exp=1", rx_ready); end
    @(negedge clk); rst = 1'b0;
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", rd); end
    // load both FIFOs, then reset asynchronously between clock edges
    bus_write(2'd2, 32'h33);
    rx_send(8'h77);
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL prereset_status got=%h exp=3", rd); end
    #3 rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got=%h exp=00", tx_data); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
    @(negedge clk); rst = 1'b0;
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL postrst_status got=%h exp=1", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL postrst_rx_empty got=%h exp=0", rd); end
  endtask

  task automatic test_sel();
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sel_status got=%h exp=1", rd); end
    @(negedge clk);
    addr = 32'h9000_0000;
    re = 1'b1;
    #1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_off got=%b exp=0", sel); end
    @(negedge clk);
    re = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sel_off_read got=%h exp=0", rdata); end
    addr = BASE | 32'hC;
    #1;
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_on got=%b exp=1", sel); end
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    bus_write(2'd2, 32'hFFFF_FF41);
    bus_write(2'd2, 32'h42);
    tx_ready = 1'b1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL tx_first got=%b/%h exp=1/41", tx_valid, tx_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL tx_second got=%b/%h exp=1/42", tx_valid, tx_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
    // push into an empty FIFO while ready: no bypass, byte is held one cycle
    bus_write(2'd2, 32'h5A);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin errors++; $display("FAIL tx_nobypass got=%b/%h exp=1/5a", tx_valid, tx_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_nobypass_pop got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
    // RO register write must not disturb anything
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ro_write got=%h exp=1", rd); end
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_write(2'd2, 32'h10 + i);
      if (i < 8) exp_q.push_back(8'(8'h10 + i));
    end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL txfull_status got=%h exp=0", rd); end
    // full FIFO: simultaneous pop and push both happen
    @(negedge clk);
    addr = BASE | 32'h8; wdata = 32'h99; we = 4'hF; tx_ready = 1'b1;
    @(negedge clk);
    we = 4'h0; tx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h99);
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL txfull_pushpop got=%h exp=0", rd); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_q.pop_front();
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b) begin errors++; $display("FAIL txfull_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b); end
      @(negedge clk);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL txfull_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    rx_send(8'h64);
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL rx_status got=%h exp=3", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h64) begin errors++; $display("FAIL rx_data got=%h exp=64", rd); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rx_status_after got=%h exp=1", rd); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rx_empty_read got=%h exp=0", rd); end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 10; i++) begin
      rx_send(8'hA0 + 8'(i));
      if (i < 8) exp_q.push_back(8'(8'hA0 + i));
    end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL ovf_status got=%h exp=7", rd); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ovf_cleared got=%h exp=3", rd); end
    bus_read(2'd3, rd);
`ifdef UART_OVF_COUNT_EN
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ovf_cnt got=%h exp=2", rd); end
`else
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovf_cnt_off got=%h exp=0", rd); end
`endif
    bus_write(2'd3, 32'h1234);
    bus_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovf_cnt_clear got=%h exp=0", rd); end
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_q.pop_front();
      bus_read(2'd1, rd);
      checks++; if (rd !== {24'b0, exp_b}) begin errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd, exp_b); end
    end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ovf_final_status got=%h exp=1", rd); end
  endtask

  task automatic test_simultaneous();
    // RX read on empty with a push: read returns 0, push lands
    @(negedge clk);
    addr = BASE | 32'h4; re = 1'b1; rx_data = 8'h5C; rx_valid = 1'b1;
    @(negedge clk);
    re = 1'b0; rx_valid = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sim_empty_read got=%h exp=0", rdata); end
    bus_read(2'd1, rd);
    checks++; if (rd !== 32'h5C) begin errors++; $display("FAIL sim_empty_push got=%h exp=5c", rd); end
    // full RX: read and push in one cycle, no overflow
    for (int i = 0; i < 8; i++) begin
      rx_send(8'hB0 + 8'(i));
      if (i > 0) exp_q.push_back(8'(8'hB0 + i));
    end
    exp_q.push_back(8'hC0);
    @(negedge clk);
    addr = BASE | 32'h4; re = 1'b1; rx_data = 8'hC0; rx_valid = 1'b1;
    @(negedge clk);
    re = 1'b0; rx_valid = 1'b0;
    checks++; if (rdata !== 32'hB0) begin errors++; $display("FAIL sim_full_read got=%h exp=b0", rdata); end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL sim_full_status got=%h exp=3", rd); end
    for (int i = 0; i < 8; i++) begin
      exp_b = exp_q.pop_front();
      bus_read(2'd1, rd);
      checks++; if (rd !== {24'b0, exp_b}) begin errors++; $display("FAIL sim_drain%0d got=%h exp=%h", i, rd, exp_b); end
    end
    bus_read(2'd0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sim_final_status got=%h exp=1", rd); end
  endtask

  initial begin
    test_reset();
    test_sel();
    test_tx();
    test_tx_full();
    test_rx();
    test_rx_overflow();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
